// File: rtl/snake_game_fsm.sv
// snake_game_fsm: top-level game sequencer for the snake game.
//   Runs IDLE -> PLAY -> WIN/LOSE -> IDLE. Games start on a button press edge. PLAY ends on
//   a collision or when the score reaches the target. While in PLAY, a movement tick paces
//   the snake engine.
//   Optional feature: define PAUSE_EN to enable PLAY <-> PAUSE toggling with PAUSE_BTN.
//
// Ports
//   CLOCK         in   system clock, rising edge
//   RESET         in   synchronous, active-high
//   PUSH_BUTTONS  in   debounced button levels [BTN_W]
//   SCORE_IN      in   unsigned score from the snake engine [SCORE_W]
//   COLLISION     in   level, snake hit wall/self
//   PAUSE_BTN     in   level, pause toggle request (PAUSE_EN builds only)
//   STATE_OUT     out  registered state code [3]
//   TICK_OUT      out  registered one-cycle movement pulse
//   GAME_OVER     out  registered, high in WIN or LOSE
//
// state | meaning
// IDLE  | waiting for a button press edge
// PLAY  | game running, movement ticks generated
// PAUSE | game frozen, tick counter held (PAUSE_EN only)
// WIN   | score target reached, held END_HOLD cycles
// LOSE  | collision, held END_HOLD cycles
module snake_game_fsm #(
    parameter int BTN_W     = 4,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 10,
    parameter int TICK_DIV  = 16,
    parameter int END_HOLD  = 32
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [BTN_W-1:0]   PUSH_BUTTONS,
    input  logic [SCORE_W-1:0] SCORE_IN,
    input  logic               COLLISION,
    input  logic               PAUSE_BTN,
    output logic [2:0]         STATE_OUT,
    output logic               TICK_OUT,
    output logic               GAME_OVER
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(END_HOLD - 1);
    localparam logic [31:0]   WIN_SCORE_U = 32'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BTN_W-1:0]    btn_q;
    logic [TW-1:0]       tick_cnt_q;
    logic [HW-1:0]       hold_cnt_q;
    logic                tick_q;
    logic                game_over_q;
    logic                btn_rise;
    logic                pause_rise;
    logic                score_win;
    logic                in_end_d;

    assign btn_rise  = |(PUSH_BUTTONS & ~btn_q);
    // Widened compare so a target beyond the score range simply never matches.
    assign score_win = 32'(SCORE_IN) >= WIN_SCORE_U;
    assign in_end_d  = (state_d == S_WIN) || (state_d == S_LOSE);

`ifdef PAUSE_EN
    logic pause_q;
    assign pause_rise = PAUSE_BTN & ~pause_q;
`else
    logic unused_pause_btn;
    assign unused_pause_btn = PAUSE_BTN;
    assign pause_rise       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (btn_rise) state_d = S_PLAY;
            S_PLAY: begin
                if (COLLISION)       state_d = S_LOSE;
                else if (score_win)  state_d = S_WIN;
                else if (pause_rise) state_d = S_PAUSE;
            end
`ifdef PAUSE_EN
            S_PAUSE: if (pause_rise) state_d = S_PLAY;
`else
            S_PAUSE: state_d = S_IDLE;
`endif
            S_WIN, S_LOSE: if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            tick_q      <= 1'b0;
            game_over_q <= 1'b0;
            tick_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            // Tracking the live buttons during reset makes a button held through reset
            // look already-pressed, so it must be released and pressed again to start.
            btn_q       <= PUSH_BUTTONS;
`ifdef PAUSE_EN
            pause_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            btn_q       <= PUSH_BUTTONS;
            game_over_q <= in_end_d;
            tick_q      <= 1'b0;
`ifdef PAUSE_EN
            pause_q     <= PAUSE_BTN;
`endif
            // Counter only advances while staying in PLAY; it freezes across PAUSE and
            // no tick is issued on the edge that leaves PLAY.
            if (state_q == S_IDLE && state_d == S_PLAY) begin
                tick_cnt_q <= '0;
            end else if (state_q == S_PLAY && state_d == S_PLAY) begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_q <= '0;
                    tick_q     <= 1'b1;
                end else begin
                    tick_cnt_q <= tick_cnt_q + TW'(1);
                end
            end else if (state_d == S_IDLE) begin
                tick_cnt_q <= '0;
            end

            if ((state_q == S_WIN || state_q == S_LOSE) && state_d == state_q)
                hold_cnt_q <= hold_cnt_q + HW'(1);
            else
                hold_cnt_q <= '0;
        end
    end

    assign STATE_OUT = state_q;
    assign TICK_OUT  = tick_q;
    assign GAME_OVER = game_over_q;

endmodule
